// File: rtl/msg_arbiter_pkg.sv
// Shared types and helpers for the message-channel arbiter and its round-robin picker.
package msg_arb_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      ABORT = 2'd2
   } state_t;

   // Index visited at step 'off' of a scan that starts just after 'last' and wraps at n.
   function automatic int rr_index(input int last, input int off, input int n);
      return (last + off) % n;
   endfunction

endpackage

// File: rtl/msg_arbiter_if.sv
// Framed message bundle: NREQ requester lanes in, one shared channel out, plus status.
interface msg_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_head;
   logic [NREQ-1:0]    req_tail;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               out_valid;
   logic               out_head;
   logic               out_tail;
   logic [DW-1:0]      out_data;
   logic               out_ready;
   logic [NREQ-1:0]    grant;
   logic               msg_ip;
   logic               abort;

   modport master (
      output req_valid, req_head, req_tail, req_data, out_ready,
      input  req_ready, out_valid, out_head, out_tail, out_data, grant, msg_ip, abort
   );

   modport slave (
      input  req_valid, req_head, req_tail, req_data, out_ready,
      output req_ready, out_valid, out_head, out_tail, out_data, grant, msg_ip, abort
   );
endinterface

// File: rtl/msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', scanning upward with wrap.
// Zero latency; no flow control of its own.
module rr_pick
   import msg_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] pick,
   output logic            any
);

   logic [IW-1:0] sel;
   logic          found;

   always_comb begin
      pick  = '0;
      sel   = '0;
      found = 1'b0;
      any   = |req;
      for (int k = 1; k <= NREQ; k++) begin
         sel = IW'(rr_index(int'(last), k, NREQ));
         if (!found && req[sel]) begin
            pick[sel] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/msg_arbiter.sv
// Round-robin message arbiter: grant locked head..tail, watchdog aborts stalled messages.
// 1-cycle arbitration, 1-cycle gap between messages; out_ready passes straight to the owner's req_ready.
module msg_arbiter
   import msg_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic         clock,
   input  logic         reset,
   msg_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t          state;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   last_grant;
   logic [CW-1:0]   stall;
   logic            msg_ip;
   logic            abort;

   logic [NREQ-1:0] pick;
   logic            any;
   logic [IW-1:0]   pick_idx;
   logic [CW-1:0]   stall_nxt;
   logic            xfer;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req  (bus.req_valid & bus.req_head),
      .last (last_grant),
      .pick (pick),
      .any  (any)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = IW'(i);
      end
   end

   // Channel mux: only the locked owner is visible, and only while sending.
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_head  = 1'b0;
      bus.out_tail  = 1'b0;
      bus.out_data  = '0;
      bus.req_ready = '0;
      if (state == SEND) begin
         bus.out_valid       = bus.req_valid[gidx];
         bus.out_head        = bus.req_head[gidx];
         bus.out_tail        = bus.req_tail[gidx];
         bus.out_data        = bus.req_data[int'(gidx) * DW +: DW];
         bus.req_ready[gidx] = bus.out_ready;
      end
   end

   assign xfer      = bus.out_valid & bus.out_ready;
   assign stall_nxt = stall + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         gidx       <= '0;
         last_grant <= IW'(NREQ - 1);
         stall      <= '0;
         msg_ip     <= 1'b0;
         abort      <= 1'b0;
      end else begin
         abort <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  state  <= SEND;
                  grant  <= pick;
                  gidx   <= pick_idx;
                  stall  <= '0;
                  msg_ip <= 1'b1;
               end
            end
            SEND: begin
               if (xfer) begin
                  stall <= '0;
                  if (bus.out_tail) begin
                     state      <= IDLE;
                     grant      <= '0;
                     last_grant <= gidx;
                     msg_ip     <= 1'b0;
                  end
               end else if (!bus.req_valid[gidx] && TIMEOUT != 0) begin
                  // Only a silent owner counts; out_ready backpressure never aborts.
                  stall <= stall_nxt;
                  if (stall_nxt == CW'(TIMEOUT)) begin
                     state  <= ABORT;
                     abort  <= 1'b1;
                     msg_ip <= 1'b0;
                  end
               end
            end
            ABORT: begin
               state      <= IDLE;
               grant      <= '0;
               last_grant <= gidx;
               stall      <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant  = grant;
   assign bus.msg_ip = msg_ip;
   assign bus.abort  = abort;

endmodule

// File: tb/tb_msg_arbiter.sv
// Randomized and directed bench for msg_arbiter against a message-level reference model.
module tb_msg_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 8;
   localparam int TIMEOUT = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   msg_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
   msg_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic          head;
      logic          tail;
      logic [DW-1:0] data;
   } beat_t;

   beat_t sbuf [NREQ][64];
   int    rd   [NREQ];
   int    wr   [NREQ];
   bit    en   [NREQ];
   bit    ordy;
   bit    mon_on = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [NREQ-1:0] o_grant, o_ready;
   logic            o_msg_ip, o_abort, o_valid;
   int              ab_n;
   int              log_n;
   int              log_src  [256];
   logic [DW-1:0]   log_data [256];
   bit              log_head [256];

   int m_own, m_last, m_cnt;
   bit m_kill;

   task automatic push_msg(input int src, input int len, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++) begin
         sbuf[src][wr[src]] = '{head: (b == 0), tail: (b == len - 1), data: base + DW'(b)};
         wr[src]++;
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NREQ; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++) if (rd[i] != wr[i]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive sources, sample at negedge, check against the model, advance.
   task automatic tick();
      logic [NREQ-1:0]    pv, ph, pt, exp_grant, exp_ready;
      logic [NREQ*DW-1:0] pd;
      logic               exp_valid, send;
      int                 src;
      pv = '0; ph = '0; pt = '0; pd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (en[i] && rd[i] != wr[i]) begin
            pv[i]            = 1'b1;
            ph[i]            = sbuf[i][rd[i]].head;
            pt[i]            = sbuf[i][rd[i]].tail;
            pd[i*DW +: DW]   = sbuf[i][rd[i]].data;
         end
      end
      bus.req_valid = pv;
      bus.req_head  = ph;
      bus.req_tail  = pt;
      bus.req_data  = pd;
      bus.out_ready = ordy;
      @(negedge clock);
      o_grant  = bus.grant;
      o_ready  = bus.req_ready;
      o_msg_ip = bus.msg_ip;
      o_abort  = bus.abort;
      o_valid  = bus.out_valid;
      if (o_abort === 1'b1) ab_n++;

      send      = (m_own >= 0) && !m_kill;
      exp_grant = '0;
      exp_ready = '0;
      exp_valid = 1'b0;
      if (m_own >= 0) exp_grant[m_own] = 1'b1;
      if (send) begin
         exp_ready[m_own] = ordy;
         exp_valid        = pv[m_own];
      end
      if (mon_on) begin
         checks++;
         if ({o_grant, o_ready, o_msg_ip, o_abort, o_valid} !==
             {exp_grant, exp_ready, send, m_kill, exp_valid}) begin
            errors++;
            $display("FAIL model_ctrl t=%0t got grant=%b ready=%b ip=%b abort=%b valid=%b want %b %b %b %b %b",
                     $time, o_grant, o_ready, o_msg_ip, o_abort, o_valid,
                     exp_grant, exp_ready, send, m_kill, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            if ({bus.out_head, bus.out_tail, bus.out_data} !== {ph[m_own], pt[m_own], pd[m_own*DW +: DW]}) begin
               errors++;
               $display("FAIL model_beat t=%0t got %b%b %h want %b%b %h", $time, bus.out_head, bus.out_tail,
                        bus.out_data, ph[m_own], pt[m_own], pd[m_own*DW +: DW]);
            end
         end
      end

      if (bus.out_valid === 1'b1 && ordy && log_n < 256) begin
         src = -1;
         for (int i = 0; i < NREQ; i++) if (o_grant[i]) src = i;
         log_src[log_n]  = src;
         log_data[log_n] = bus.out_data;
         log_head[log_n] = bus.out_head;
         log_n++;
      end
      for (int i = 0; i < NREQ; i++) if (pv[i] && bus.req_ready[i] === 1'b1) rd[i]++;

      // Reference: message-granular round robin with a silent-owner watchdog.
      if (reset) begin
         m_own = -1; m_last = NREQ - 1; m_cnt = 0; m_kill = 1'b0;
      end else if (m_kill) begin
         m_last = m_own; m_own = -1; m_kill = 1'b0;
      end else if (m_own < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            src = (m_last + k) % NREQ;
            if (m_own < 0 && pv[src] && ph[src]) m_own = src;
         end
         m_cnt = 0;
      end else if (pv[m_own] && ordy) begin
         m_cnt = 0;
         if (pt[m_own]) begin
            m_last = m_own;
            m_own  = -1;
         end
      end else if (!pv[m_own]) begin
         m_cnt++;
         if (m_cnt == TIMEOUT) m_kill = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      flush();
      for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
      ordy  = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset  = 1'b0;
      mon_on = 1'b1;
      ab_n   = 0;
      log_n  = 0;
   endtask

   task automatic drain(input int maxc, output int n);
      n = 0;
      while (!all_empty() && n < maxc) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      tick();
      checks++;
      if ({o_grant, o_ready, o_msg_ip, o_abort, o_valid} !== '0) begin
         errors++;
         $display("FAIL reset_state got %b want 0", {o_grant, o_ready, o_msg_ip, o_abort, o_valid});
      end
   endtask

   task automatic test_single();
      apply_reset();
      push_msg(2, 3, 8'h20);
      tick();
      checks++;
      if ({o_grant, o_ready} !== 8'h00) begin
         errors++; $display("FAIL single_idle got %b %b want 0000 0000", o_grant, o_ready);
      end
      tick();
      checks++;
      if ({o_grant, o_ready, o_msg_ip} !== {4'b0100, 4'b0100, 1'b1}) begin
         errors++; $display("FAIL single_grant got %b %b %b want 0100 0100 1", o_grant, o_ready, o_msg_ip);
      end
      tick();
      tick();
      tick();
      checks++;
      if ({o_grant, o_msg_ip} !== 5'b0) begin
         errors++; $display("FAIL single_end got %b %b want 0000 0", o_grant, o_msg_ip);
      end
      checks++;
      if (log_n !== 3 || log_data[0] !== 8'h20 || log_data[1] !== 8'h21 || log_data[2] !== 8'h22 || log_src[2] !== 2) begin
         errors++; $display("FAIL single_beats got n=%0d %h %h %h want 3 20 21 22", log_n, log_data[0], log_data[1], log_data[2]);
      end
   endtask

   task automatic test_contention();
      int n;
      int hs [4];
      int k;
      apply_reset();
      push_msg(0, 2, 8'h00);
      push_msg(1, 2, 8'h10);
      push_msg(3, 2, 8'h30);
      push_msg(0, 2, 8'h40);
      drain(60, n);
      checks++;
      if (!all_empty() || n !== 12) begin
         errors++; $display("FAIL contention_cycles got %0d want 12", n);
      end
      k = 0;
      for (int i = 0; i < log_n; i++) if (log_head[i] && k < 4) begin hs[k] = log_src[i]; k++; end
      checks++;
      if (k !== 4 || hs[0] !== 0 || hs[1] !== 1 || hs[2] !== 3 || hs[3] !== 0) begin
         errors++; $display("FAIL contention_order got %0d,%0d,%0d,%0d want 0,1,3,0", hs[0], hs[1], hs[2], hs[3]);
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit ok;
      apply_reset();
      push_msg(1, 4, 8'h50);
      n = 0;
      while (!all_empty() && n < 40) begin
         ordy = (n % 2 == 0);
         tick();
         n++;
      end
      ordy = 1'b1;
      tick();
      ok = (log_n == 4) && all_empty();
      for (int i = 0; i < 4; i++) if (log_data[i] !== 8'h50 + 8'(i) || log_src[i] !== 1) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++; $display("FAIL backpressure_beats got n=%0d first=%h want 4 beats 50..53", log_n, log_data[0]);
      end
      checks++;
      if (ab_n !== 0) begin
         errors++; $display("FAIL backpressure_abort got %0d want 0", ab_n);
      end
   endtask

   task automatic test_watchdog();
      apply_reset();
      push_msg(0, 3, 8'h60);
      push_msg(1, 1, 8'h70);
      tick();
      tick();
      en[0] = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) tick();
      tick();
      checks++;
      if ({o_abort, o_msg_ip} !== 2'b10) begin
         errors++; $display("FAIL watchdog_pulse got abort=%b ip=%b want 1 0", o_abort, o_msg_ip);
      end
      rd[0] = wr[0];
      en[0] = 1'b1;
      tick();
      checks++;
      if ({o_abort, o_grant} !== 5'b0) begin
         errors++; $display("FAIL watchdog_clear got abort=%b grant=%b want 0 0000", o_abort, o_grant);
      end
      tick();
      checks++;
      if (o_grant !== 4'b0010) begin
         errors++; $display("FAIL watchdog_next got %b want 0010", o_grant);
      end
      checks++;
      if (ab_n !== 1) begin
         errors++; $display("FAIL watchdog_count got %0d want 1", ab_n);
      end
   endtask

   task automatic test_single_beat();
      logic [NREQ-1:0] g [4];
      apply_reset();
      push_msg(1, 1, 8'h81);
      push_msg(2, 1, 8'h82);
      for (int i = 0; i < 4; i++) begin
         tick();
         g[i] = o_grant;
      end
      checks++;
      if (g[0] !== 4'b0000 || g[1] !== 4'b0010 || g[2] !== 4'b0000 || g[3] !== 4'b0100 || !all_empty()) begin
         errors++; $display("FAIL single_beat_grants got %b %b %b %b want 0000 0010 0000 0100", g[0], g[1], g[2], g[3]);
      end
      checks++;
      if (log_n !== 2 || log_src[0] !== 1 || log_src[1] !== 2) begin
         errors++; $display("FAIL single_beat_order got n=%0d %0d %0d want 2 1 2", log_n, log_src[0], log_src[1]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      push_msg(2, 1, 8'h90);
      tick();
      tick();
      push_msg(1, 3, 8'hA0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      flush();
      tick();
      checks++;
      if ({o_grant, o_msg_ip, o_abort} !== 6'b0) begin
         errors++; $display("FAIL reset_mid_state got grant=%b ip=%b abort=%b want 0000 0 0", o_grant, o_msg_ip, o_abort);
      end
      push_msg(0, 1, 8'hB0);
      push_msg(3, 1, 8'hB3);
      tick();
      tick();
      checks++;
      if (o_grant !== 4'b0001 || ab_n !== 0) begin
         errors++; $display("FAIL reset_mid_last got grant=%b aborts=%0d want 0001 0", o_grant, ab_n);
      end
   endtask

   task automatic test_random();
      int total;
      int n;
      int dz [NREQ];
      apply_reset();
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
         dz[i] = 0;
         for (int m = 0; m < 3; m++) begin
            n = $urandom_range(1, 4);
            push_msg(i, n, 8'($urandom));
            total += n;
         end
      end
      n = 0;
      while (!all_empty() && n < 600) begin
         for (int i = 0; i < NREQ; i++) begin
            en[i] = (dz[i] >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            dz[i] = en[i] ? 0 : dz[i] + 1;
         end
         ordy = ($urandom_range(0, 9) < 7);
         tick();
         n++;
      end
      checks++;
      if (!all_empty() || log_n !== total) begin
         errors++; $display("FAIL random_drain got beats=%0d cycles=%0d want beats=%0d", log_n, n, total);
      end
      checks++;
      if (ab_n !== 0) begin
         errors++; $display("FAIL random_abort got %0d want 0", ab_n);
      end
   endtask

   initial begin
      reset         = 1'b1;
      ordy          = 1'b1;
      bus.req_valid = '0;
      bus.req_head  = '0;
      bus.req_tail  = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b1;
      m_own = -1; m_last = NREQ - 1; m_cnt = 0; m_kill = 1'b0;
      ab_n  = 0;
      log_n = 0;
      flush();
      @(posedge clock);
      #1;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_watchdog();
      test_single_beat();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msg_arbiter.md
# msg_arbiter

Round-robin arbiter that shares one message channel among NREQ framed message sources. Each source presents beats with valid/head/tail framing. A grant is locked from the head beat through the tail beat, so messages never interleave. Sits in front of the IDLE/SEND message FSM datapath and drives its `valid`/`head` inputs; also exports `msg_ip` and an abort watchdog.

## Interface
- NREQ, 4 — number of requesters, 2..8
- DW, 8 — beat data width
- TIMEOUT, 16 — max consecutive stalled cycles inside a message before abort; 0 disables the watchdog
- clock  in  1  — single clock, all state on posedge
- reset  in  1  — synchronous, active-high
- req_valid  in  NREQ  — beat valid per requester
- req_head  in  NREQ  — beat is first of message
- req_tail  in  NREQ  — beat is last of message (head&tail = single-beat message)
- req_data  in  NREQ*DW  — requester i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  — beat accepted from requester i
- out_valid  out  1  — channel beat valid
- out_head  out  1  — channel head flag
- out_tail  out  1  — channel tail flag
- out_data  out  DW  — channel data
- out_ready  in  1  — channel accepts beat
- grant  out  NREQ  — one-hot current owner, 0 when idle
- msg_ip  out  1  — message in progress (state SEND)
- abort  out  1  — one-cycle pulse, message killed by watchdog

## Operation
- States: IDLE, SEND, ABORT.
- IDLE: eligible(i) = req_valid[i] & req_head[i]. If any requester is eligible, pick the first eligible index after last_grant, scanning upward and wrapping. Register grant = onehot(pick) and go to SEND. No beat transfers in IDLE; all req_ready = 0.
- SEND: out_* = req_*[g] muxed from owner g. req_ready[g] = out_ready; the other req_ready bits stay 0. A transfer occurs when out_valid & out_ready.
- On a transfer with tail: go to IDLE, set last_grant = g, clear grant.
- A head seen mid-message is passed through unchanged and not checked.
- Watchdog: stall counter clears on every transfer and increments on each SEND cycle with req_valid[g] = 0. When the counter reaches TIMEOUT, go to ABORT. Stalls caused by out_ready = 0 do not count.
- ABORT: out_valid = 0, all req_ready = 0, abort = 1 for one cycle. Then go to IDLE, set last_grant = g, clear grant.
- Non-head beats from non-owners are never accepted; those requesters wait.
- Reset values: state IDLE, grant 0, last_grant NREQ-1 (so requester 0 wins first), counter 0, msg_ip 0, abort 0, out_valid 0, req_ready 0.

## Timing
- Arbitration latency: 1 cycle. Head is eligible at edge N; the head beat can transfer at edge N+1.
- Back-to-back messages: tail transfers at edge N, IDLE at N, next head transfers at N+2 at the earliest. This gives a minimum 1-cycle gap.
- out_* and req_ready are combinational from registered state/grant plus the current inputs.
- Reset asserted mid-message: at the next edge, state returns to IDLE and grant clears. The partial message is dropped with no abort pulse.
- Simultaneous tail transfer and watchdog expiry: the transfer wins, so the FSM goes to IDLE with no abort.
- TIMEOUT = 1: the first stalled cycle causes the abort.

## Structure
- Package `msg_arb_pkg`:
  - state enum (IDLE, SEND, ABORT)
  - state width constant
  - helper function for the round-robin rotate index
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the NREQ request vector and last_grant; outputs are the one-hot pick and an any-request flag. It is reused by other schedulers.
- Counter width: clog2(TIMEOUT+1).

## Test plan
- Single requester: req 2 sends head@t, mid, tail with out_ready = 1 -> grant = 0100 one cycle after head; three transfers; msg_ip falls after tail; req_ready[2] = 1 only in SEND.
- Contention: reqs 0, 1, 3 all present head together, 2-beat messages, after reset -> service order 0, 1, 3, then 0 again; 1-cycle IDLE gap between messages.
- Backpressure: out_ready toggles 1/0 during a 4-beat message from req 1 -> beats delivered in order, no duplication, no abort (TIMEOUT = 4).
- Watchdog: TIMEOUT = 4; req 0 sends head, then drops valid for 4 cycles -> abort pulses once on the cycle after the 4th stall; grant clears; next winner is req 1 if requesting.
- Single-beat messages: head&tail on reqs 1 and 2 -> each takes 2 cycles (arbitrate plus transfer); grant order 1, 2.
- Reset mid-message: assert reset for 1 cycle during beat 2 of 3 -> grant = 0, msg_ip = 0, abort = 0, last_grant = NREQ-1 next cycle.
